// File: rtl/pwm_bank.sv
// Bank of CHANNELS PWM outputs sharing one prescaled period counter.
// Compare values are double-buffered so that writes never disturb a running period.
module pwm_bank #(
   parameter int CHANNELS   = 16,
   parameter int CNT_W      = 12,
   parameter int PRESCALE_W = 8,
   parameter int CH_W       = $clog2(CHANNELS)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  enable_i,
   input  logic [PRESCALE_W-1:0] prescale_i,
   input  logic                  invert_i,
   input  logic                  update_mode_i,
   input  logic                  wr_en_i,
   input  logic [CH_W-1:0]       wr_chan_i,
   input  logic [CNT_W-1:0]      wr_on_i,
   input  logic [CNT_W-1:0]      wr_off_i,
   input  logic                  wr_full_on_i,
   input  logic                  wr_full_off_i,
   output logic [CNT_W-1:0]      counter_o,
   output logic                  period_start_o,
   output logic [CHANNELS-1:0]   pwm_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [PRESCALE_W-1:0] presc_cnt_p0;
   logic [CNT_W-1:0]      cnt_p0;
   logic                  period_start_p0;
   logic                  tick;
   logic                  wrap;
   logic                  commit;

   logic [CNT_W-1:0]      act_on   [CHANNELS];
   logic [CNT_W-1:0]      act_off  [CHANNELS];
   logic [CHANNELS-1:0]   act_fon;
   logic [CHANNELS-1:0]   act_foff;
   logic [CNT_W-1:0]      pend_on  [CHANNELS];
   logic [CNT_W-1:0]      pend_off [CHANNELS];
   logic [CHANNELS-1:0]   pend_fon;
   logic [CHANNELS-1:0]   pend_foff;
   logic [CHANNELS-1:0]   pend_flag;

   logic [CHANNELS-1:0]   hit_p0;
   logic [CHANNELS-1:0]   pwm_p1;

   // Window compare; full_off dominates full_on, and on==off is an empty window.
   function automatic logic ch_active(input logic [CNT_W-1:0] n,
                                      input logic [CNT_W-1:0] on,
                                      input logic [CNT_W-1:0] off,
                                      input logic             fon,
                                      input logic             foff);
      logic in_win;
      if (on < off)      in_win = (n >= on) && (n < off);
      else if (on > off) in_win = (n >= on) || (n < off);
      else               in_win = 1'b0;
      if (foff) return 1'b0;
      if (fon)  return 1'b1;
      return in_win;
   endfunction

   // >= rather than == so that lowering prescale_i below the running count cannot lock up.
   assign tick   = enable_i && (presc_cnt_p0 >= prescale_i);
   assign wrap   = tick && (cnt_p0 == CNT_MAX);
   assign commit = !enable_i || update_mode_i || wrap;

   // Stage p0: prescaler and period counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc_cnt_p0    <= '0;
         cnt_p0          <= '0;
         period_start_p0 <= 1'b0;
      end else if (!enable_i) begin
         presc_cnt_p0    <= '0;
         cnt_p0          <= '0;
         period_start_p0 <= 1'b0;
      end else begin
         if (tick) begin
            presc_cnt_p0 <= '0;
            cnt_p0       <= cnt_p0 + 1'b1;
         end else begin
            presc_cnt_p0 <= presc_cnt_p0 + 1'b1;
         end
         period_start_p0 <= wrap;
      end
   end

   // Out-of-range channel indices never match any c, so they are dropped here.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int c = 0; c < CHANNELS; c++) begin
            act_on[c]    <= '0;
            act_off[c]   <= '0;
            act_fon[c]   <= 1'b0;
            act_foff[c]  <= 1'b1;
            pend_on[c]   <= '0;
            pend_off[c]  <= '0;
            pend_fon[c]  <= 1'b0;
            pend_foff[c] <= 1'b1;
            pend_flag[c] <= 1'b0;
         end
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (commit && pend_flag[c]) begin
               act_on[c]    <= pend_on[c];
               act_off[c]   <= pend_off[c];
               act_fon[c]   <= pend_fon[c];
               act_foff[c]  <= pend_foff[c];
               pend_flag[c] <= 1'b0;
            end
            // A write in a commit clock wins the flag, so it waits for the next commit.
            if (wr_en_i && (wr_chan_i == CH_W'(c))) begin
               pend_on[c]   <= wr_on_i;
               pend_off[c]  <= wr_off_i;
               pend_fon[c]  <= wr_full_on_i;
               pend_foff[c] <= wr_full_off_i;
               pend_flag[c] <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      hit_p0 = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         hit_p0[c] = ch_active(cnt_p0, act_on[c], act_off[c], act_fon[c], act_foff[c]) ^ invert_i;
      end
   end

   // Stage p1: registered outputs, one clock behind counter_o
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)        pwm_p1 <= '0;
      else if (!enable_i) pwm_p1 <= {CHANNELS{invert_i}};
      else                pwm_p1 <= hit_p0;
   end

   assign counter_o      = cnt_p0;
   assign period_start_o = period_start_p0;
   assign pwm_o          = pwm_p1;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: table of compare windows plus hand-written
// sequences for commit timing, prescaler, sleep, invert and reset.
module tb_pwm_bank;

   localparam int CHANNELS   = 4;
   localparam int CNT_W      = 4;
   localparam int PRESCALE_W = 8;
   localparam int CH_W       = 2;

   logic                  clk_i = 1'b0;
   logic                  rst_ni;
   logic                  enable_i;
   logic [PRESCALE_W-1:0] prescale_i;
   logic                  invert_i;
   logic                  update_mode_i;
   logic                  wr_en_i;
   logic [CH_W-1:0]       wr_chan_i;
   logic [CNT_W-1:0]      wr_on_i;
   logic [CNT_W-1:0]      wr_off_i;
   logic                  wr_full_on_i;
   logic                  wr_full_off_i;
   logic [CNT_W-1:0]      counter_o;
   logic                  period_start_o;
   logic [CHANNELS-1:0]   pwm_o;

   int vectors    = 0;
   int miscompares = 0;

   typedef struct {
      int          ch;
      logic [3:0]  on;
      logic [3:0]  off;
      logic        fon;
      logic        foff;
      logic [15:0] exp_mask;
   } vec_t;

   vec_t vecs [9];

   pwm_bank #(
      .CHANNELS  (CHANNELS),
      .CNT_W     (CNT_W),
      .PRESCALE_W(PRESCALE_W)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .enable_i      (enable_i),
      .prescale_i    (prescale_i),
      .invert_i      (invert_i),
      .update_mode_i (update_mode_i),
      .wr_en_i       (wr_en_i),
      .wr_chan_i     (wr_chan_i),
      .wr_on_i       (wr_on_i),
      .wr_off_i      (wr_off_i),
      .wr_full_on_i  (wr_full_on_i),
      .wr_full_off_i (wr_full_off_i),
      .counter_o     (counter_o),
      .period_start_o(period_start_o),
      .pwm_o         (pwm_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic write_ch(input int ch, input logic [3:0] on, input logic [3:0] off,
                           input logic fon, input logic foff);
      wr_en_i       = 1'b1;
      wr_chan_i     = CH_W'(ch);
      wr_on_i       = on;
      wr_off_i      = off;
      wr_full_on_i  = fon;
      wr_full_off_i = foff;
      step();
      wr_en_i = 1'b0;
   endtask

   task automatic wait_cnt(input logic [3:0] v);
      for (int i = 0; i < 64 && counter_o != v; i++) step();
      if (counter_o != v) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_cnt: counter_o %0d never reached %0d", counter_o, v);
      end
   endtask

   // Bit n of m is the output level that reflects count n.
   task automatic collect(input int ch, output logic [15:0] m);
      m = '0;
      wait_cnt(4'd1);
      for (int n = 0; n < 16; n++) begin
         m[n] = pwm_o[ch];
         step();
      end
   endtask

   initial begin
      logic [15:0] mask;
      logic [15:0] partial;
      logic [3:0]  exp_cnt;
      logic [3:0]  c0;
      logic [3:0]  idx;
      int          pulses;
      int          n;

      vecs[0] = '{1, 4'd2,  4'd10, 1'b0, 1'b0, 16'h03FC};
      vecs[1] = '{2, 4'd12, 4'd3,  1'b0, 1'b0, 16'hF007};
      vecs[2] = '{2, 4'd5,  4'd5,  1'b0, 1'b0, 16'h0000};
      vecs[3] = '{3, 4'd2,  4'd10, 1'b1, 1'b1, 16'h0000};
      vecs[4] = '{3, 4'd2,  4'd10, 1'b1, 1'b0, 16'hFFFF};
      vecs[5] = '{0, 4'd0,  4'd8,  1'b0, 1'b0, 16'h00FF};
      vecs[6] = '{0, 4'd15, 4'd0,  1'b0, 1'b0, 16'h8000};
      vecs[7] = '{1, 4'd0,  4'd15, 1'b0, 1'b0, 16'h7FFF};
      vecs[8] = '{2, 4'd14, 4'd1,  1'b0, 1'b0, 16'hC001};

      rst_ni        = 1'b0;
      enable_i      = 1'b1;
      prescale_i    = '0;
      invert_i      = 1'b1;
      update_mode_i = 1'b1;
      wr_en_i       = 1'b0;
      wr_chan_i     = '0;
      wr_on_i       = '0;
      wr_off_i      = '0;
      wr_full_on_i  = 1'b0;
      wr_full_off_i = 1'b0;

      // Reset state, then the inactive level after release
      repeat (3) step();
      check("reset_cnt", counter_o, 0);
      check("reset_ps", period_start_o, 0);
      check("reset_pwm", pwm_o, 0);
      rst_ni = 1'b1;
      step();
      check("rel_cnt", counter_o, 1);
      check("rel_pwm_inv", pwm_o, 4'hF);
      invert_i = 1'b0;
      step();
      check("rel_pwm", pwm_o, 4'h0);

      // Free-running count with one period_start per wrap
      exp_cnt = counter_o;
      pulses  = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         exp_cnt = exp_cnt + 4'd1;
         check("cnt_seq", counter_o, exp_cnt);
         check("ps_align", period_start_o, (exp_cnt == 4'd0));
         if (period_start_o) pulses++;
      end
      check("ps_pulses", pulses, 2);
      check("pwm_default", pwm_o, 4'h0);

      // Compare windows, immediate-commit mode
      for (int v = 0; v < 9; v++) begin
         write_ch(vecs[v].ch, vecs[v].on, vecs[v].off, vecs[v].fon, vecs[v].foff);
         step();
         step();
         collect(vecs[v].ch, mask);
         check($sformatf("window_v%0d", v), mask, vecs[v].exp_mask);
      end

      // Wrap-commit mode: mid-period write waits for wrap; write at wrap lands one period later
      write_ch(0, 4'd0, 4'd12, 1'b0, 1'b0);
      step();
      step();
      update_mode_i = 1'b0;
      wait_cnt(4'd6);
      write_ch(0, 4'd0, 4'd8, 1'b0, 1'b0);
      partial = '0;
      for (int j = 0; j < 10; j++) begin
         idx = counter_o - 4'd1;
         partial[idx] = pwm_o[0];
         if (counter_o == 4'd15) begin
            wr_en_i       = 1'b1;
            wr_chan_i     = 2'd0;
            wr_on_i       = 4'd0;
            wr_off_i      = 4'd4;
            wr_full_on_i  = 1'b0;
            wr_full_off_i = 1'b0;
         end
         step();
         wr_en_i = 1'b0;
      end
      check("m0_old_period", partial, 16'h0FC0);
      collect(0, mask);
      check("m0_first_commit", mask, 16'h00FF);
      collect(0, mask);
      check("m0_second_commit", mask, 16'h000F);

      // Global invert while running (ch0 0..3, ch1 0..14, ch2 14..0, ch3 full_on)
      invert_i = 1'b1;
      step();
      wait_cnt(4'd6);
      check("invert_run", pwm_o, 4'b0101);
      invert_i = 1'b0;
      step();
      wait_cnt(4'd6);
      check("plain_run", pwm_o, 4'b1010);

      // Prescaler: one tick per 4 clocks, then drop to 0 mid-count
      prescale_i = 8'd3;
      for (int r = 0; r < 3; r++) begin
         c0 = counter_o;
         n  = 0;
         while (counter_o == c0 && n < 10) begin
            step();
            n++;
         end
         check("presc_interval", n, 4);
      end
      step();
      step();
      prescale_i = 8'd0;
      c0 = counter_o;
      step();
      check("presc_drop_first", counter_o, c0 + 4'd1);
      step();
      check("presc_drop_next", counter_o, c0 + 4'd2);

      // Sleep mid-period, sleep level with invert, write during sleep commits at once
      wait_cnt(4'd9);
      check("pre_sleep_ch3", pwm_o[3], 1'b1);
      enable_i = 1'b0;
      step();
      check("sleep_cnt", counter_o, 0);
      check("sleep_pwm", pwm_o, 4'h0);
      check("sleep_ps", period_start_o, 0);
      invert_i = 1'b1;
      step();
      check("sleep_pwm_inv", pwm_o, 4'hF);
      check("sleep_cnt_held", counter_o, 0);
      invert_i = 1'b0;
      write_ch(3, 4'd0, 4'd0, 1'b0, 1'b0);
      step();
      enable_i = 1'b1;
      step();
      check("wake_cnt", counter_o, 1);
      check("wake_ps", period_start_o, 0);
      check("wake_pwm", pwm_o, 4'b0111);

      // Async reset discards a pending write
      wait_cnt(4'd5);
      write_ch(1, 4'd0, 4'd0, 1'b1, 1'b0);
      step();
      rst_ni = 1'b0;
      #1;
      check("arst_cnt", counter_o, 0);
      check("arst_pwm", pwm_o, 0);
      check("arst_ps", period_start_o, 0);
      step();
      rst_ni = 1'b1;
      step();
      check("post_rst_pwm", pwm_o, 4'h0);
      collect(1, mask);
      check("post_rst_ch1_a", mask, 16'h0000);
      collect(1, mask);
      check("post_rst_ch1_b", mask, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete, %0d vectors applied", vectors);
      $fatal(1);
   end

endmodule
